// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arb_pkg;

  localparam int BEATS_DEFAULT = 4;
  localparam int BUS_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Round-robin selector: first set request at or after rr_ptr, wrapping.
module rr_pick
  import mem_bus_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);

  int            w_cand;
  logic [IW-1:0] w_cand_idx;

  // Scan from the far end back to rr_ptr so the nearest requester wins.
  always_comb begin
    any        = |req;
    idx        = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = int'(rr_ptr) + k;
      if (w_cand >= NREQ) w_cand = w_cand - NREQ;
      w_cand_idx = IW'(w_cand);
      if (req[w_cand_idx]) idx = w_cand_idx;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner of the mem_controller AddrData bus: one ADDR cycle plus BEATS data beats per grant.
// States: IDLE wait for req | ADDR drive address | DATA move beats | GAP bus turnaround, done pulse.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int BEATS = BEATS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetH,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_rw,
  input  logic [NREQ*BUS_W-1:0] req_addr,
  input  logic [NREQ*BUS_W-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       wr_beat,
  output logic [BUS_W-1:0]      rd_data,
  output logic [NREQ-1:0]       rd_valid,
  output logic [NREQ-1:0]       done,
  output logic                  AddrValid,
  output logic                  rw,
  inout  wire  [BUS_W-1:0]      AddrData
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    w_pick_idx;
  logic             w_any;
  logic [BUS_W-1:0] r_addr_q;
  logic             r_rw_q;
  logic [BW-1:0]    r_beat;
  logic [BUS_W-1:0] r_rd_data;
  logic [NREQ-1:0]  r_rd_valid;
  logic [NREQ-1:0]  w_onehot;
  logic             w_drive;
  logic [BUS_W-1:0] w_bus_out;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .any    (w_any),
    .idx    (w_pick_idx)
  );

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (resetH) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_idx      <= '0;
      r_addr_q   <= '0;
      r_rw_q     <= 1'b0;
      r_beat     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_idx    <= w_pick_idx;
            r_addr_q <= req_addr[w_pick_idx*BUS_W +: BUS_W];
            r_rw_q   <= req_rw[w_pick_idx];
          end
        end
        ADDR: r_beat <= '0;
        DATA: begin
          r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
          // Read data is captured at the edge ending each beat, so rd_valid lags by one cycle.
          if (r_rw_q) begin
            r_rd_data  <= AddrData;
            r_rd_valid <= w_onehot;
          end
        end
        GAP: r_rr_ptr <= (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    gnt       = '0;
    wr_beat   = '0;
    done      = '0;
    AddrValid = 1'b0;
    rw        = 1'b0;
    w_drive   = 1'b0;
    w_bus_out = '0;
    case (r_state)
      IDLE: if (w_any) w_next = ADDR;
      ADDR: begin
        AddrValid = 1'b1;
        rw        = r_rw_q;
        gnt       = w_onehot;
        w_drive   = 1'b1;
        w_bus_out = r_addr_q;
        w_next    = DATA;
      end
      DATA: begin
        rw  = r_rw_q;
        gnt = w_onehot;
        if (!r_rw_q) begin
          wr_beat   = w_onehot;
          w_drive   = 1'b1;
          w_bus_out = wr_data[r_idx*BUS_W +: BUS_W];
        end
        if (r_beat == LAST_BEAT) w_next = GAP;
      end
      GAP: begin
        done   = w_onehot;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign AddrData = w_drive ? w_bus_out : 'z;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small behavioural mem_controller on the shared bus.
module tb_mem_bus_arbiter;

  localparam int BEATS = 4;

  logic        clk;
  logic        resetH;
  logic [1:0]  req;
  logic [1:0]  req_rw;
  logic [31:0] req_addr;
  logic [31:0] wr_data;
  logic [1:0]  gnt;
  logic [1:0]  wr_beat;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  done;
  logic        AddrValid;
  logic        rw;
  wire  [15:0] AddrData;

  int n_vec;
  int n_err;

  mem_bus_arbiter #(.NREQ(2), .BEATS(BEATS)) dut (
    .clk       (clk),
    .resetH    (resetH),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .wr_data   (wr_data),
    .gnt       (gnt),
    .wr_beat   (wr_beat),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .AddrValid (AddrValid),
    .rw        (rw),
    .AddrData  (AddrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: latches address on AddrValid, then serves or absorbs BEATS beats.
  logic [15:0] mem [0:255];
  logic [7:0]  m_addr;
  logic        m_rw;
  int          m_cnt;
  logic        mem_drv;
  logic [15:0] mem_val;

  always @(posedge clk) begin
    if (resetH) begin
      m_cnt <= 0;
    end else if (AddrValid) begin
      m_addr <= AddrData[7:0];
      m_rw   <= rw;
      m_cnt  <= BEATS;
    end else if (m_cnt > 0) begin
      if (!m_rw) mem[m_addr] <= AddrData;
      m_addr <= m_addr + 8'd1;
      m_cnt  <= m_cnt - 1;
    end
  end

  assign mem_drv  = (m_cnt > 0) && m_rw;
  assign mem_val  = mem[m_addr];
  assign AddrData = mem_drv ? mem_val : 16'hzzzz;

  wire bus_float = (AddrData === 16'hzzzz) || (AddrData === 16'h0000);

  // Requester write-data model: advances on each consumed beat.
  logic [15:0] wdat [0:1][0:3];
  logic [1:0]  wp [0:1];
  logic        wp_clr;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (resetH || wp_clr) wp[i] <= 2'd0;
      else if (wr_beat[i])  wp[i] <= wp[i] + 2'd1;
    end
  end

  always_comb wr_data = {wdat[1][wp[1]], wdat[0][wp[0]]};

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear_wp;
    wp_clr = 1'b1;
    tick;
    wp_clr = 1'b0;
  endtask

  task automatic test_reset;
    resetH = 1'b1;
    tick; tick;
    n_vec++; if (gnt !== 2'b00)       begin n_err++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_vec++; if (wr_beat !== 2'b00)   begin n_err++; $display("FAIL reset_wr_beat: got %b expected 00", wr_beat); end
    n_vec++; if (rd_valid !== 2'b00)  begin n_err++; $display("FAIL reset_rd_valid: got %b expected 00", rd_valid); end
    n_vec++; if (done !== 2'b00)      begin n_err++; $display("FAIL reset_done: got %b expected 00", done); end
    n_vec++; if (AddrValid !== 1'b0)  begin n_err++; $display("FAIL reset_addrvalid: got %b expected 0", AddrValid); end
    n_vec++; if (rw !== 1'b0)         begin n_err++; $display("FAIL reset_rw: got %b expected 0", rw); end
    n_vec++; if (rd_data !== 16'h0)   begin n_err++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    n_vec++; if (!bus_float)          begin n_err++; $display("FAIL reset_bus: got %h expected zzzz", AddrData); end
    resetH = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    clear_wp;
    for (int k = 0; k < 4; k++) wdat[0][k] = 16'(16'h00A1 + k);
    req_rw[0] = 1'b0;
    req_addr[15:0] = 16'h2010;
    req = 2'b01;
    tick;
    n_vec++; if (AddrValid !== 1'b1)    begin n_err++; $display("FAIL wr_addrvalid: got %b expected 1", AddrValid); end
    n_vec++; if (AddrData !== 16'h2010) begin n_err++; $display("FAIL wr_addr: got %h expected 2010", AddrData); end
    n_vec++; if (gnt !== 2'b01)         begin n_err++; $display("FAIL wr_gnt: got %b expected 01", gnt); end
    n_vec++; if (rw !== 1'b0)           begin n_err++; $display("FAIL wr_rw: got %b expected 0", rw); end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_vec++; if (AddrData !== 16'(16'h00A1 + k)) begin n_err++; $display("FAIL wr_beat_data%0d: got %h expected %h", k, AddrData, 16'(16'h00A1 + k)); end
      n_vec++; if (wr_beat !== 2'b01 || AddrValid !== 1'b0) begin n_err++; $display("FAIL wr_beat_flag%0d: got wr_beat=%b av=%b expected 01/0", k, wr_beat, AddrValid); end
    end
    tick;
    n_vec++; if (done !== 2'b01 || gnt !== 2'b00) begin n_err++; $display("FAIL wr_gap: got done=%b gnt=%b expected 01/00", done, gnt); end
    n_vec++; if (!bus_float) begin n_err++; $display("FAIL wr_gap_bus: got %h expected zzzz", AddrData); end
    req = 2'b00;
    tick;
    n_vec++; if (done !== 2'b00) begin n_err++; $display("FAIL wr_done_width: got %b expected 00", done); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (mem[8'(8'h10 + k)] !== 16'(16'h00A1 + k)) begin n_err++; $display("FAIL wr_mem%0d: got %h expected %h", k, mem[8'(8'h10 + k)], 16'(16'h00A1 + k)); end
    end
  endtask

  task automatic test_single_read;
    for (int k = 0; k < 4; k++) wdat[0][k] = 16'hFFFF;
    req_rw[0] = 1'b1;
    req_addr[15:0] = 16'h2010;
    req = 2'b01;
    tick;
    n_vec++; if (AddrValid !== 1'b1 || rw !== 1'b1) begin n_err++; $display("FAIL rd_addr_cycle: got av=%b rw=%b expected 1/1", AddrValid, rw); end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_vec++; if (AddrData !== 16'(16'h00A1 + k)) begin n_err++; $display("FAIL rd_bus%0d: got %h expected %h", k, AddrData, 16'(16'h00A1 + k)); end
      n_vec++; if (wr_beat !== 2'b00 || gnt !== 2'b01) begin n_err++; $display("FAIL rd_flags%0d: got wr_beat=%b gnt=%b expected 00/01", k, wr_beat, gnt); end
      if (k == 0) begin
        n_vec++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL rd_valid_lag: got %b expected 00", rd_valid); end
      end else begin
        n_vec++; if (rd_valid !== 2'b01 || rd_data !== 16'(16'h00A0 + k)) begin n_err++; $display("FAIL rd_data%0d: got v=%b d=%h expected 01/%h", k - 1, rd_valid, rd_data, 16'(16'h00A0 + k)); end
      end
    end
    tick;
    n_vec++; if (rd_valid !== 2'b01 || rd_data !== 16'h00A4) begin n_err++; $display("FAIL rd_data3: got v=%b d=%h expected 01/00a4", rd_valid, rd_data); end
    n_vec++; if (done !== 2'b01) begin n_err++; $display("FAIL rd_done: got %b expected 01", done); end
    req = 2'b00;
    tick;
    n_vec++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL rd_valid_end: got %b expected 00", rd_valid); end
  endtask

  task automatic test_round_robin;
    int cnt;
    resetH = 1'b1;
    tick;
    resetH = 1'b0;
    for (int k = 0; k < 4; k++) begin wdat[0][k] = 16'hFFFF; wdat[1][k] = 16'hFFFF; end
    req_rw   = 2'b11;
    req_addr = {16'h2020, 16'h2010};
    req      = 2'b11;
    cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      tick;
      if (AddrValid) begin
        if (cnt < 4) begin
          n_vec++; if (gnt !== ((cnt % 2 == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL rr_order%0d: got %b expected %b", cnt, gnt, (cnt % 2 == 0) ? 2'b01 : 2'b10); end
          n_vec++; if (n != 1 + 7 * cnt) begin n_err++; $display("FAIL rr_spacing%0d: got cycle %0d expected %0d", cnt, n, 1 + 7 * cnt); end
        end
        cnt++;
        if (cnt == 4) req = 2'b00;
      end
    end
    n_vec++; if (cnt != 4) begin n_err++; $display("FAIL rr_count: got %0d bursts expected 4", cnt); end
  endtask

  task automatic test_read_then_write;
    clear_wp;
    for (int k = 0; k < 4; k++) begin wdat[1][k] = 16'hFFFF; wdat[0][k] = 16'(16'h00B1 + k); end
    req_rw   = 2'b10;
    req_addr = {16'h2010, 16'h2030};
    req      = 2'b10;
    tick;
    n_vec++; if (gnt !== 2'b10 || AddrData !== 16'h2010 || rw !== 1'b1) begin n_err++; $display("FAIL rw_r_addr: got gnt=%b bus=%h rw=%b expected 10/2010/1", gnt, AddrData, rw); end
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_vec++; if (AddrData !== 16'(16'h00A1 + k) || wr_beat !== 2'b00) begin n_err++; $display("FAIL rw_r_beat%0d: got bus=%h wr_beat=%b expected %h/00", k, AddrData, wr_beat, 16'(16'h00A1 + k)); end
    end
    tick;
    n_vec++; if (done !== 2'b10 || rd_valid !== 2'b10 || rd_data !== 16'h00A4) begin n_err++; $display("FAIL rw_r_gap: got done=%b v=%b d=%h expected 10/10/00a4", done, rd_valid, rd_data); end
    n_vec++; if (!bus_float) begin n_err++; $display("FAIL rw_gap_bus: got %h expected zzzz", AddrData); end
    req = 2'b01;
    tick;
    n_vec++; if (!bus_float || AddrValid !== 1'b0 || gnt !== 2'b00) begin n_err++; $display("FAIL rw_idle: got bus=%h av=%b gnt=%b expected zzzz/0/00", AddrData, AddrValid, gnt); end
    tick;
    n_vec++; if (gnt !== 2'b01 || AddrData !== 16'h2030 || rw !== 1'b0) begin n_err++; $display("FAIL rw_w_addr: got gnt=%b bus=%h rw=%b expected 01/2030/0", gnt, AddrData, rw); end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_vec++; if (AddrData !== 16'(16'h00B1 + k) || wr_beat !== 2'b01) begin n_err++; $display("FAIL rw_w_beat%0d: got bus=%h wr_beat=%b expected %h/01", k, AddrData, wr_beat, 16'(16'h00B1 + k)); end
    end
    tick;
    n_vec++; if (done !== 2'b01) begin n_err++; $display("FAIL rw_w_done: got %b expected 01", done); end
    req = 2'b00;
    tick;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (mem[8'(8'h30 + k)] !== 16'(16'h00B1 + k)) begin n_err++; $display("FAIL rw_mem%0d: got %h expected %h", k, mem[8'(8'h30 + k)], 16'(16'h00B1 + k)); end
    end
  endtask

  task automatic test_reset_mid_burst;
    clear_wp;
    for (int k = 0; k < 4; k++) wdat[0][k] = 16'(16'h00C1 + k);
    req_rw[0] = 1'b0;
    req_addr[15:0] = 16'h2040;
    req = 2'b01;
    tick;
    n_vec++; if (gnt !== 2'b01) begin n_err++; $display("FAIL rst_mid_gnt: got %b expected 01", gnt); end
    tick; tick; tick;
    n_vec++; if (AddrData !== 16'h00C3 || wr_beat !== 2'b01) begin n_err++; $display("FAIL rst_mid_beat2: got bus=%h wr_beat=%b expected 00c3/01", AddrData, wr_beat); end
    resetH = 1'b1;
    req = 2'b00;
    tick;
    n_vec++; if (gnt !== 2'b00 || AddrValid !== 1'b0 || wr_beat !== 2'b00) begin n_err++; $display("FAIL rst_mid_idle: got gnt=%b av=%b wr_beat=%b expected 00/0/00", gnt, AddrValid, wr_beat); end
    n_vec++; if (done !== 2'b00 || !bus_float) begin n_err++; $display("FAIL rst_mid_bus: got done=%b bus=%h expected 00/zzzz", done, AddrData); end
    resetH = 1'b0;
    tick;
    n_vec++; if (done !== 2'b00 || AddrValid !== 1'b0) begin n_err++; $display("FAIL rst_mid_nodone: got done=%b av=%b expected 00/0", done, AddrValid); end
    clear_wp;
    for (int k = 0; k < 4; k++) begin wdat[0][k] = 16'(16'h00D1 + k); wdat[1][k] = 16'hFFFF; end
    req_rw   = 2'b10;
    req_addr = {16'h2020, 16'h2050};
    req      = 2'b11;
    tick;
    n_vec++; if (gnt !== 2'b01 || AddrData !== 16'h2050) begin n_err++; $display("FAIL rst_ptr: got gnt=%b bus=%h expected 01/2050", gnt, AddrData); end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_vec++; if (AddrData !== 16'(16'h00D1 + k) || wr_beat !== 2'b01) begin n_err++; $display("FAIL rst_fresh_beat%0d: got bus=%h wr_beat=%b expected %h/01", k, AddrData, wr_beat, 16'(16'h00D1 + k)); end
    end
    tick;
    n_vec++; if (done !== 2'b01) begin n_err++; $display("FAIL rst_fresh_done: got %b expected 01", done); end
    req = 2'b00;
    tick;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (mem[8'(8'h50 + k)] !== 16'(16'h00D1 + k)) begin n_err++; $display("FAIL rst_fresh_mem%0d: got %h expected %h", k, mem[8'(8'h50 + k)], 16'(16'h00D1 + k)); end
    end
  endtask

  task automatic test_drop_in_addr;
    clear_wp;
    for (int k = 0; k < 4; k++) wdat[0][k] = 16'(16'h00E1 + k);
    req_rw[0] = 1'b0;
    req_addr[15:0] = 16'h2060;
    req = 2'b01;
    tick;
    n_vec++; if (gnt !== 2'b01 || AddrValid !== 1'b1) begin n_err++; $display("FAIL drop_addr: got gnt=%b av=%b expected 01/1", gnt, AddrValid); end
    req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_vec++; if (AddrData !== 16'(16'h00E1 + k) || wr_beat !== 2'b01) begin n_err++; $display("FAIL drop_beat%0d: got bus=%h wr_beat=%b expected %h/01", k, AddrData, wr_beat, 16'(16'h00E1 + k)); end
    end
    tick;
    n_vec++; if (done !== 2'b01) begin n_err++; $display("FAIL drop_done: got %b expected 01", done); end
    tick;
    tick;
    n_vec++; if (AddrValid !== 1'b0 || gnt !== 2'b00) begin n_err++; $display("FAIL drop_no_rearb: got av=%b gnt=%b expected 0/00", AddrValid, gnt); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (mem[8'(8'h60 + k)] !== 16'(16'h00E1 + k)) begin n_err++; $display("FAIL drop_mem%0d: got %h expected %h", k, mem[8'(8'h60 + k)], 16'(16'h00E1 + k)); end
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    resetH   = 1'b1;
    req      = 2'b00;
    req_rw   = 2'b00;
    req_addr = '0;
    wp_clr   = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) wdat[i][k] = 16'hFFFF;
    test_reset;
    test_single_write;
    test_single_read;
    test_round_robin;
    test_read_then_write;
    test_reset_mid_burst;
    test_drop_in_addr;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the multiplexed AddrData bus of one mem_controller between NREQ CPU-side requesters.
- Round-robin arbitration; for each granted requester it sequences one full bus burst: 1 address cycle plus 4 data beats.
- Drives AddrValid, rw and AddrData (address and write data), and captures read data returned by mem_controller.
- Sits between the requester agents and the mem_controller bus pins; does no page decode.

Parameters:
- NREQ, 2, number of requesters (2..4).
- BEATS, 4, data beats per burst; must match mem_controller.

Ports:
- clk  in  1  system clock, shared with mem_controller.
- resetH  in  1  synchronous active-high reset.
- req  in  NREQ  request[i], level-held until done[i].
- req_rw  in  NREQ  1=read, 0=write; sampled at grant.
- req_addr  in  NREQ*16  address for requester i, bits [16i+15:16i]; sampled at grant.
- wr_data  in  NREQ*16  write beat data for requester i; must be valid while wr_beat[i]=1.
- gnt  out  NREQ  one-hot; high from the ADDR cycle through the last beat.
- wr_beat  out  NREQ  write beat consumed this cycle; requester advances its data on this edge.
- rd_data  out  16  registered read beat data.
- rd_valid  out  NREQ  rd_data valid for requester i for one cycle.
- done  out  NREQ  one-cycle pulse in the GAP cycle after the last beat.
- AddrValid  out  1  to mem_controller.
- rw  out  1  to mem_controller.
- AddrData  inout  16  shared bus.

Behaviour:
- Reset (synchronous, on a clk edge with resetH=1):
  - state=IDLE, rr_ptr=0.
  - gnt, wr_beat, rd_valid, done, AddrValid, rw all 0; rd_data=0.
  - AddrData tristated ('z).
- States: IDLE, ADDR, DATA (beat counter 0..BEATS-1), GAP.
- IDLE:
  - If any req bit is set, pick the winner, starting the search at rr_ptr and wrapping.
  - On the next edge: latch idx, addr_q=req_addr[idx], rw_q=req_rw[idx]; go to ADDR.
  - If no req, stay in IDLE.
- ADDR, one cycle:
  - AddrValid=1, rw=rw_q, AddrData=addr_q, gnt[idx]=1.
  - Next: DATA with beat=0.
- DATA, BEATS cycles; AddrValid=0 and rw holds rw_q.
  - Write: AddrData=wr_data[idx], wr_beat[idx]=1 every beat.
  - Read: AddrData tristated; at the edge ending each beat, rd_data<=AddrData and rd_valid[idx]=1 in the following cycle.
  - Rd_valid therefore lags each beat by one cycle; the last rd_valid coincides with GAP.
  - Beat counter wraps at BEATS-1, then go to GAP.
- GAP, one cycle:
  - Bus tristated, gnt=0, done[idx]=1.
  - rr_ptr=(idx+1) mod NREQ. Next state: IDLE.
  - GAP provides read-to-write turnaround and lets mem_controller return to its wait state.
- Throughput and latency:
  - Minimum per-burst cost: 1 IDLE + 1 ADDR + BEATS + 1 GAP = 7 cycles.
  - Latency from req rising in IDLE to AddrValid is 1 cycle.
- Boundary conditions:
  - Simultaneous requests: the lowest index at or after rr_ptr wins. Two continuously requesting agents alternate strictly.
  - A req dropped mid-burst is ignored; bursts are never aborted. Only reset aborts.
  - req/req_rw/req_addr changes after grant are ignored; addr_q and rw_q are held.
  - A requester still holding req after done re-enters arbitration at lowest priority (rr_ptr has moved past it).
  - Reset mid-burst: returns to IDLE on that edge and tristates the bus immediately; no done is issued; rr_ptr resets to 0.
  - The arbiter never drives AddrData during read beats or GAP, so there is no contention with mem_controller.

Decomposition:
- Package mem_bus_arb_pkg:
  - state_t enum {IDLE, ADDR, DATA, GAP}.
  - BEATS_DEFAULT=4, BUS_W=16.
- Sub-module rr_pick:
  - Parameterised NREQ round-robin selector.
  - Inputs req, rr_ptr; outputs any, idx.
- Top-level mem_bus_arbiter contains the FSM, beat counter, latches and tristate control.

Test Plan:
- Single write: req=01, req_rw[0]=0, addr=16'h2010, data beats A1..A4. Required response:
  - AddrValid=1 with AddrData=2010 one cycle after req.
  - Bus carries A1, A2, A3, A4 on 4 consecutive cycles with wr_beat[0]=1.
  - done[0] pulses in GAP.
  - Memory 0x10..0x13 reads back A1..A4.
- Single read of 0x2010 after the write: 4 rd_valid[0] pulses carrying A1..A4 in order; the arbiter never drives the bus during DATA.
- Simultaneous req=11 from reset: grant order is 0, 1, 0, 1 over four bursts, each burst 7 cycles apart at AddrValid.
- Read by requester 1 followed immediately by a write by requester 0: GAP cycle shows AddrData='z, no X on the bus at any point, write data correct.
- resetH=1 during beat 2 of a write: next cycle state=IDLE, gnt=0, AddrData='z, no done. A fresh request then completes normally.
- Requester 0 drops req in ADDR: the burst still completes all 4 beats and done[0] pulses.
